uart_tx_fifo: RTL and testbench

UART transmitter with a small input FIFO. It serialises bytes onto the tx line, and its bit timing comes from an external one-cycle baud strobe, the same tick clk_divider_UART generates. It is the transmit end of the board's serial link and is fed by control logic through a valid/ready write port. Line format is 8N1 by default; parity and stop-bit count are configurable.

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO; bit timing comes from an external
// one-cycle baud strobe. Frame: start, DATA_BITS (LSB first), optional parity, stop bits.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 2,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_count,
  output logic [2:0]           state_dbg
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int SW    = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [FIFO_AW:0] FULL      = (FIFO_AW + 1)'(DEPTH);
  localparam logic [BW-1:0]    BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [SW-1:0]    STOP_LAST = SW'(STOP_BITS - 1);
  localparam logic             HAS_PAR   = (PARITY != 0);
  localparam logic             ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [FIFO_AW:0]     count;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // Write port handshake: a byte is taken on a posedge where din_valid && din_ready.
  // din_ready depends only on registered occupancy, never on din_valid.
  assign din_ready  = (count != FULL);
  assign push       = din_valid && din_ready;
  assign fifo_count = count;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM state
  state_t               state;
  state_t               state_n;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_n;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_cnt_n;
  logic [SW-1:0]        stop_cnt;
  logic [SW-1:0]        stop_cnt_n;
  logic                 par_bit;
  logic                 par_n;
  logic                 tx_q;
  logic                 tx_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      par_bit  <= par_n;
      tx_q     <= tx_n;
    end
  end

  // Every transition happens on a baud_tick; the load path is shared by IDLE and
  // the final stop period so consecutive frames run without an idle gap.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    par_n      = par_bit;
    tx_n       = tx_q;
    pop        = 1'b0;
    if (baud_tick) begin
      case (state)
        S_IDLE: begin
          tx_n = 1'b1;
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = head;
            par_n   = (^head) ^ ODD_PAR;
            tx_n    = 1'b0;
            state_n = S_START;
          end
        end
        S_START: begin
          tx_n      = shift[0];
          bit_cnt_n = '0;
          state_n   = S_DATA;
        end
        S_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            tx_n       = HAS_PAR ? par_bit : 1'b1;
            stop_cnt_n = '0;
            state_n    = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            shift_n   = shift >> 1;
            tx_n      = shift_n[0];
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          tx_n       = 1'b1;
          stop_cnt_n = '0;
          state_n    = S_STOP;
        end
        S_STOP: begin
          tx_n = 1'b1;
          if (stop_cnt == STOP_LAST) begin
            if (count != '0) begin
              pop     = 1'b1;
              shift_n = head;
              par_n   = (^head) ^ ODD_PAR;
              tx_n    = 1'b0;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
        default: begin
          tx_n    = 1'b1;
          state_n = S_IDLE;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter variants share one stimulus stream; a line
// decoder rebuilds each frame and checks it against a per-variant queue of accepted bytes.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [7:0] din;
  logic       din_valid;

  logic       tx_v    [4];
  logic       busy_v  [4];
  logic       ready_v [4];
  logic [2:0] cnt_v   [4];
  logic [2:0] st_v    [4];

  int checks   = 0;
  int failures = 0;

  bit tick_en  = 1'b0;
  int tick_div = 4;
  int tick_cnt = 0;

  // variant 0: 8N1, 1: even parity, 2: odd parity, 3: two stop bits
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_AW(2), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .din(din), .din_valid(din_valid),
    .din_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]),
    .state_dbg(st_v[0]));
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_AW(2), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .din(din), .din_valid(din_valid),
    .din_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]),
    .state_dbg(st_v[1]));
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_AW(2), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .din(din), .din_valid(din_valid),
    .din_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]),
    .state_dbg(st_v[2]));
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_AW(2), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .din(din), .din_valid(din_valid),
    .din_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]),
    .state_dbg(st_v[3]));

  // clock / baud strobe
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        if (tick_cnt >= tick_div - 1) begin
          baud_tick = 1'b1;
          tick_cnt  = 0;
        end else begin
          baud_tick = 1'b0;
          tick_cnt++;
        end
      end else begin
        baud_tick = 1'b0;
        tick_cnt  = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int par_of(input int i);
    return (i == 1) ? 1 : (i == 2) ? 2 : 0;
  endfunction

  function automatic int stp_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  // scoreboard queues of accepted bytes, one per variant
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];
  logic [7:0] exp_q3[$];

  task automatic push_exp(input int i, input logic [7:0] b);
    case (i)
      0: exp_q0.push_back(b);
      1: exp_q1.push_back(b);
      2: exp_q2.push_back(b);
      default: exp_q3.push_back(b);
    endcase
  endtask

  task automatic pop_exp(input int i, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    case (i)
      0: if (exp_q0.size() > 0) begin b = exp_q0.pop_front(); ok = 1'b1; end
      1: if (exp_q1.size() > 0) begin b = exp_q1.pop_front(); ok = 1'b1; end
      2: if (exp_q2.size() > 0) begin b = exp_q2.pop_front(); ok = 1'b1; end
      default: if (exp_q3.size() > 0) begin b = exp_q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  task automatic clear_exp(input int i);
    case (i)
      0: exp_q0.delete();
      1: exp_q1.delete();
      2: exp_q2.delete();
      default: exp_q3.delete();
    endcase
  endtask

  // reference model: FIFO occupancy plus line decoder state
  int         model_cnt [4];
  int         cnt_pre   [4];
  bit         in_frame  [4];
  int         pos       [4];
  logic [7:0] acc       [4];
  logic       cur       [4];

  // One baud interval has just begun; tx holds its level until the next tick.
  task automatic do_interval(input int i);
    logic       lvl;
    logic       p;
    logic [7:0] b;
    bit         ok;
    int         len;
    lvl    = tx_v[i];
    cur[i] = lvl;
    len    = 9 + ((par_of(i) != 0) ? 1 : 0) + stp_of(i);
    if (!in_frame[i]) begin
      if (lvl == 1'b0) begin
        check("start_needs_queued_byte", cnt_pre[i] > 0, 1);
        check("busy_at_start", busy_v[i], 1);
        in_frame[i] = 1'b1;
        pos[i]      = 1;
        acc[i]      = 8'h00;
        if (model_cnt[i] > 0) model_cnt[i]--;
      end else begin
        check("idle_with_queued_byte", cnt_pre[i], 0);
        check("busy_idle", busy_v[i], 0);
      end
    end else begin
      check("busy_in_frame", busy_v[i], 1);
      if (pos[i] <= 8) begin
        acc[i][pos[i]-1] = lvl;
      end else if (par_of(i) != 0 && pos[i] == 9) begin
        p = (^acc[i]) ^ (par_of(i) == 2);
        check("parity_bit", lvl, p);
      end else begin
        check("stop_bit", lvl, 1);
      end
      pos[i]++;
      if (pos[i] == len) begin
        pop_exp(i, b, ok);
        check("frame_expected", ok, 1);
        if (ok) check("frame_byte", acc[i], b);
        in_frame[i] = 1'b0;
      end
    end
  endtask

  // monitor: snapshot inputs at the active edge, compare on the falling edge
  initial begin
    bit         t;
    bit         v;
    bit         r;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      model_cnt[i] = 0;
      cnt_pre[i]   = 0;
      in_frame[i]  = 1'b0;
      pos[i]       = 0;
      acc[i]       = 8'h00;
      cur[i]       = 1'b1;
    end
    forever begin
      @(posedge clk);
      t = baud_tick;
      v = din_valid;
      d = din;
      r = rst;
      for (int i = 0; i < 4; i++) begin
        cnt_pre[i] = model_cnt[i];
        if (r && v && model_cnt[i] < 4) begin
          model_cnt[i]++;
          push_exp(i, d);
        end
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!rst) begin
          model_cnt[i] = 0;
          in_frame[i]  = 1'b0;
          cur[i]       = 1'b1;
          clear_exp(i);
          check("reset_tx", tx_v[i], 1);
          check("reset_busy", busy_v[i], 0);
        end else if (t && r) begin
          do_interval(i);
        end else begin
          check("tx_holds_between_ticks", tx_v[i], cur[i]);
        end
        check("fifo_count", cnt_v[i], model_cnt[i]);
        check("din_ready", ready_v[i], model_cnt[i] < 4);
      end
    end
  end

  // driver tasks
  task automatic push_byte(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      #1;
      done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (in_frame[i] || model_cnt[i] != 0 || q_size(i) != 0) done = 1'b0;
      end
    end
    check("drain_within_budget", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (busy_v[0]) seen = 1'b1;
    end
    check("busy_within_budget", seen, 1);
  endtask

  task automatic reset_mid_frame(input logic [7:0] b, input logic tx_before);
    tick_div = 4;
    push_byte(b);
    push_byte(8'h11);
    push_byte(8'h22);
    wait_busy(100);
    repeat (10) @(posedge clk);
    @(posedge clk);
    #2;
    check("tx_before_reset", tx_v[0], tx_before);
    check("queued_before_reset", cnt_v[0], 2);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("async_reset_tx", tx_v[i], 1);
      check("async_reset_busy", busy_v[i], 0);
      check("async_reset_count", cnt_v[i], 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("no_tx_after_reset", tx_v[0], 1);
    check("no_busy_after_reset", busy_v[0], 0);
  endtask

  // watchdog
  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst       = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      check("rst_tx", tx_v[i], 1);
      check("rst_busy", busy_v[i], 0);
      check("rst_ready", ready_v[i], 1);
      check("rst_count", cnt_v[i], 0);
      check("rst_state", st_v[i], 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    tick_div = 4;
    tick_en  = 1'b1;
    push_byte(8'h55);
    drain(400);

    push_byte(8'hA3);
    check("ready_after_first_push", ready_v[0], 1);
    push_byte(8'h0F);
    check("ready_after_second_push", ready_v[0], 1);
    drain(400);

    tick_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 1; k <= 6; k++) begin
      din       = 8'(k);
      din_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    @(negedge clk);
    check("full_ready_low", ready_v[0], 0);
    check("full_count", cnt_v[0], 4);
    @(posedge clk);
    #1;
    tick_en = 1'b1;
    drain(1000);

    push_byte(8'h07);
    drain(400);
    push_byte(8'h00);
    drain(400);

    // random traffic with varying tick spacing, including back-to-back ticks
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) tick_div = $urandom_range(1, 5);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
      push_byte(8'($urandom_range(0, 255)));
    end
    drain(3000);

    reset_mid_frame(8'hFF, 1'b1);
    reset_mid_frame(8'h00, 1'b0);

    push_byte(8'h3C);
    drain(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
